// File: rtl/seq_det_pkg.sv
// Shared constants, state encoding and sizing helper for the parametrised serial pattern detector.
package seq_det_pkg;

  localparam int unsigned PAT_W_MIN = 2;
  localparam int unsigned PAT_W_MAX = 16;

  typedef enum logic {
    FILLING = 1'b0,
    ARMED   = 1'b1
  } fill_state_e;

  // Bits needed to count 0..pat_w-1 accepted bits.
  function automatic int unsigned fill_width(input int unsigned pat_w);
    return (pat_w <= 2) ? 1 : $clog2(pat_w);
  endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear; a clear and an increment in the same cycle yield 1.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_d;

  always_comb begin
    count_d = clr ? '0 : count;
    if (inc && (count_d != '1)) begin
      count_d = count_d + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_d;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Mealy serial pattern detector with loadable pattern and overlap control.
// Define SEQDET_MATCH_CNT_EN to add the saturating match counter (match_count / cnt_clr ports).
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             in_valid,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
`ifdef SEQDET_MATCH_CNT_EN
  output logic [CNT_W-1:0] match_count,
  input  logic             cnt_clr,
`endif
  output logic             out
);

  localparam int unsigned FILL_W = fill_width(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  generate
    if ((PAT_W < PAT_W_MIN) || (PAT_W > PAT_W_MAX)) begin : g_bad_pat_w
      $error("seq_detector_param: PAT_W out of range");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
      $error("seq_detector_param: CNT_W must be at least 1");
    end
  endgenerate

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-2:0] hist, hist_d, hist_shift;
  logic [FILL_W-1:0] fill, fill_d;
  fill_state_e state;
  logic accept;
  logic match;

  // Newest bit enters at hist[0]; a 2-bit pattern keeps only the last bit.
  generate
    if (PAT_W == 2) begin : g_shift_min
      assign hist_shift = in;
    end else begin : g_shift
      assign hist_shift = {hist[PAT_W-3:0], in};
    end
  endgenerate

  assign state  = (fill == FILL_MAX) ? ARMED : FILLING;
  assign accept = in_valid & ~pat_load;
  assign match  = accept & (state == ARMED) & ({hist, in} == pat_q);
  assign out    = match;

  // Pattern load flushes history and wins over a bit offered in the same cycle.
  always_comb begin
    pat_d  = pat_q;
    hist_d = hist;
    fill_d = fill;
    if (pat_load) begin
      pat_d  = pattern;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      if (match && !overlap) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = hist_shift;
        fill_d = (state == ARMED) ? fill : fill + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q <= '0;
      hist  <= '0;
      fill  <= '0;
    end else begin
      pat_q <= pat_d;
      hist  <= hist_d;
      fill  <= fill_d;
    end
  end

`ifdef SEQDET_MATCH_CNT_EN
  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (match),
    .clr   (cnt_clr),
    .count (match_count)
  );
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param (PAT_W=4, CNT_W=2); counter checks apply when SEQDET_MATCH_CNT_EN is defined.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_bit = 1'b0;
  logic       in_valid = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pattern = 4'b0000;
  logic       overlap = 1'b1;
  logic       cnt_clr = 1'b0;
  logic       out;
  logic [1:0] match_count;

  typedef struct {
    logic       exp_out;
    logic [1:0] exp_cnt;
    int         tag;
  } item_t;

  item_t      sb[$];
  int         checks = 0;
  int         failures = 0;
  int         tag_n = 0;
  logic [1:0] cnt_model = 2'd0;

  always #5 clk = ~clk;

  seq_detector_param #(
    .PAT_W(4),
    .CNT_W(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in_bit),
    .in_valid    (in_valid),
    .pat_load    (pat_load),
    .pattern     (pattern),
    .overlap     (overlap),
`ifdef SEQDET_MATCH_CNT_EN
    .match_count (match_count),
    .cnt_clr     (cnt_clr),
`endif
    .out         (out)
  );

`ifndef SEQDET_MATCH_CNT_EN
  assign match_count = 2'd0;
`endif

  // Monitor: every driven cycle presents one expected response, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      item_t it;
      it = sb.pop_front();
      checks++;
      if (out !== it.exp_out) begin
        failures++;
        $display("FAIL out#%0d got=%b exp=%b", it.tag, out, it.exp_out);
      end
`ifdef SEQDET_MATCH_CNT_EN
      checks++;
      if (match_count !== it.exp_cnt) begin
        failures++;
        $display("FAIL match_count#%0d got=%0d exp=%0d", it.tag, match_count, it.exp_cnt);
      end
`endif
    end
  end

  // One driven cycle: apply inputs just after the edge and queue the hand-computed out.
  task automatic step(input logic v, input logic b, input logic ld, input logic [3:0] p,
                      input logic rst_v, input logic clr, input logic exp_o);
    item_t it;
    @(posedge clk);
    #1;
    reset    = rst_v;
    in_valid = v;
    in_bit   = b;
    pat_load = ld;
    pattern  = p;
    cnt_clr  = clr;
    if (rst_v) cnt_model = 2'd0;
    it.exp_out = exp_o;
    it.exp_cnt = cnt_model;
    it.tag     = tag_n;
    tag_n++;
    sb.push_back(it);
    if (!rst_v) begin
      if (clr) cnt_model = 2'd0;
      if (exp_o && (cnt_model != 2'd3)) cnt_model = cnt_model + 2'd1;
    end
  endtask

  task automatic send(input logic [15:0] bits, input logic [15:0] exp, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, bits[i], 1'b0, 4'b0000, 1'b0, 1'b0, exp[i]);
    end
  endtask

  task automatic load(input logic [3:0] p);
    step(1'b0, 1'b0, 1'b1, p, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset: offered bits must not produce out while reset is high.
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);

    // 1: single match on the 4th bit.
    overlap = 1'b1;
    load(4'b1011);
    send(16'b1011, 16'b0001, 4);

    // 2: overlapping then non-overlapping on 1011011.
    load(4'b1011);
    send(16'b1011011, 16'b0001001, 7);
    overlap = 1'b0;
    load(4'b1011);
    send(16'b1011011, 16'b0001000, 7);
    overlap = 1'b1;

    // 3: invalid gaps with in=1 must stay silent (a valid 1 after 101 would match).
    load(4'b1011);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);

    // 4: load with a concurrent 1 after 101 discards the bit; new pattern then matches.
    load(4'b1011);
    send(16'b101, 16'b000, 3);
    step(1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0);
    send(16'b0110, 16'b0001, 4);

    // 5: reset mid-stream loses history and the pattern.
    load(4'b1011);
    send(16'b101, 16'b000, 3);
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    send(16'b1, 16'b0, 1);
    send(16'b011, 16'b000, 3);

    // 6: five overlapping matches saturate the counter; clear with a concurrent match gives 1.
    load(4'b1011);
    send(16'b1011011011011011, 16'b0001001001001001, 16);
    send(16'b01, 16'b00, 2);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
